mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, giving the number of requesters (range 2..4).
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles before abort (range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester request valid.
REQ-006 SHALL have port req_addr, input, NUM_REQ*32, per-requester address, requester i at bits [32i+31:32i].
REQ-007 SHALL have port req_data, input, NUM_REQ*32, per-requester write data, same slicing as req_addr.
REQ-008 SHALL have port req_fcn, input, NUM_REQ*2, per-requester command: 0 read, 1 write, 3 flush-all.
REQ-009 SHALL have port req_typ, input, NUM_REQ*3, per-requester mask type: 0 B, 1 BU, 2 H, 3 HU, 4 W, 5 WU.
REQ-010 SHALL have port req_ready, output, NUM_REQ, one-hot request accept.
REQ-011 SHALL have port res_valid, output, NUM_REQ, one-hot response strobe.
REQ-012 SHALL have port res_data, output, 32, response data shared by all requesters.
REQ-013 SHALL have port res_err, output, 1, qualifies res_valid; 1 means timeout abort.
REQ-014 SHALL have ports mem_req_valid (output, 1), mem_req_addr (output, 32), mem_req_data (output, 32), mem_req_fcn (output, 2) and mem_req_typ (output, 3), the shared memory request.
REQ-015 SHALL have port mem_req_ready, input, 1, memory accepts the request.
REQ-016 SHALL have ports mem_res_valid (input, 1) and mem_res_data (input, 32), the memory response.
REQ-017 SHALL have port grant, output, 5, one-hot owner in bits [NUM_REQ-1:0] with all other bits 0, meaning 0 when idle.
REQ-018 SHALL have port spurious, output, 1, a sticky flag set by a mem_res_valid outside WAIT.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE and WAIT, with exactly one transaction outstanding.
REQ-020 In IDLE with any req_valid set, the block SHALL select a winner by round-robin starting at pointer rr, assert req_ready for the winner only (combinationally, in the same cycle), capture the winner's addr/data/fcn/typ and go to ISSUE.
REQ-021 In IDLE with no req_valid set, the block SHALL hold req_ready at 0 and stay in IDLE.
REQ-022 In ISSUE, mem_req_valid SHALL be 1 with the captured fields stable; on mem_req_ready the block SHALL go to WAIT and clear the timeout counter.
REQ-023 In WAIT, on mem_res_valid, the block SHALL drive res_valid[owner]=1 and res_data=mem_res_data for exactly that cycle with res_err=0, set rr=(owner+1) mod NUM_REQ, and go to IDLE.
REQ-024 Every fcn, including write and flush-all, SHALL complete only via the WAIT response path.
REQ-025 In WAIT without a response, the counter SHALL increment; when the count reaches TIMEOUT the block SHALL pulse res_valid[owner] with res_err=1 and res_data=0, advance rr, and go to IDLE.
REQ-026 A response arriving in the same cycle as the timeout SHALL take priority: res_err=0 and the data is forwarded.
REQ-027 mem_res_valid in IDLE or ISSUE SHALL be ignored for routing and SHALL set spurious; spurious clears only on reset.
REQ-028 Minimum latency from req_ready to res_valid SHALL be 2 cycles (accept in cycle 0, issue in cycle 1, response at the earliest in cycle 2).
REQ-029 The next grant SHALL occur no earlier than the cycle after res_valid.
REQ-030 grant SHALL be valid from the cycle after acceptance through the res_valid cycle, and 0 otherwise.
REQ-031 mem_req_* fields SHALL be 0 whenever mem_req_valid=0.
REQ-032 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-033 A requester deasserting req_valid after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with rr=0, counter=0, spurious=0, and all outputs 0, asserted asynchronously.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no res_valid emitted.
REQ-036 Release of rst_n SHALL be synchronous to clk; the first grant is possible in the first cycle after release.

Verification
REQ-037 Single read: req_valid[0]=1, addr 0x100, fcn 0; mem_req_ready in cycle 1; mem_res_valid with data 0xDEADBEEF in cycle 3 -> req_ready[0] in cycle 0, mem_req_addr=0x100 in cycle 1, res_valid[0]=1 with res_data=0xDEADBEEF in cycle 3.
REQ-038 Contention: req_valid=2'b11 held for 4 transactions -> grant order 0,1,0,1.
REQ-039 Backpressure: mem_req_ready=0 for 5 cycles -> mem_req_valid and fields stay stable, no timeout counting during ISSUE.
REQ-040 Timeout: TIMEOUT=4, no response -> res_valid[owner]=1 with res_err=1 and res_data=0 on the 4th WAIT cycle, then IDLE.
REQ-041 Spurious and coincidence: mem_res_valid in IDLE -> spurious=1 and no res_valid; a response on the timeout cycle -> res_err=0 with data forwarded.
REQ-042 Reset during WAIT -> outputs 0 immediately, no res_valid, next request is granted to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that lets NUM_REQ requesters share one memory port, with one transaction outstanding.
// Ports:
//   clk, rst_n                        clock and asynchronous active-low reset
//   req_valid/addr/data/fcn/typ       per-requester request, requester i in slice i
//   req_ready                         one-hot accept, combinational in IDLE
//   res_valid, res_data, res_err      one-hot response strobe, shared data, timeout flag
//   mem_req_*                         shared memory request, all zero when not valid
//   mem_res_valid, mem_res_data       memory response
//   grant                             one-hot owner while a transaction is in flight
//   spurious                          sticky flag for a memory response outside WAIT
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_data,
  input  logic [NUM_REQ*2-1:0]   req_fcn,
  input  logic [NUM_REQ*3-1:0]   req_typ,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     res_valid,
  output logic [31:0]            res_data,
  output logic                   res_err,
  output logic                   mem_req_valid,
  output logic [31:0]            mem_req_addr,
  output logic [31:0]            mem_req_data,
  output logic [1:0]             mem_req_fcn,
  output logic [2:0]             mem_req_typ,
  input  logic                   mem_req_ready,
  input  logic                   mem_res_valid,
  input  logic [31:0]            mem_res_data,
  output logic [4:0]             grant,
  output logic                   spurious
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_owner, r_rr, w_win, w_idx;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_data;
  logic [1:0]  r_fcn;
  logic [2:0]  r_typ;
  logic        r_spur;
  logic        w_any, w_accept, w_tmo, w_fire;
  logic [3:0]  w_rv, w_win_oh, w_own_oh;
  logic [127:0] w_addr_all, w_data_all;
  logic [7:0]  w_fcn_all;
  logic [11:0] w_typ_all;
  // Requester buses padded to the four-requester maximum so selects are width-exact for any NUM_REQ.
  assign w_rv       = 4'(req_valid);
  assign w_addr_all = 128'(req_addr);
  assign w_data_all = 128'(req_data);
  assign w_fcn_all  = 8'(req_fcn);
  assign w_typ_all  = 12'(req_typ);
  assign w_any      = |req_valid;
  assign w_win_oh   = 4'b1 << w_win;
  assign w_own_oh   = 4'b1 << r_owner;
  // Scan offsets from high to low so the requester closest after rr wins.
  always_comb begin
    w_win = r_rr;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = 2'((int'(r_rr) + k) % NUM_REQ);
      if (w_rv[w_idx]) w_win = w_idx;
    end
  end
  always_comb begin
    w_accept      = rst_n && r_state == S_IDLE && w_any;
    w_tmo         = r_state == S_WAIT && r_cnt == 8'(TIMEOUT - 1);
    // A response coinciding with the timeout cycle is forwarded as a normal completion.
    w_fire        = r_state == S_WAIT && (mem_res_valid || w_tmo);
    w_next        = w_accept ? S_ISSUE :
                    (r_state == S_ISSUE && mem_req_ready) ? S_WAIT :
                    w_fire ? S_IDLE : r_state;
    req_ready     = w_accept ? w_win_oh[NUM_REQ-1:0] : '0;
    res_valid     = w_fire ? w_own_oh[NUM_REQ-1:0] : '0;
    res_data      = (w_fire && mem_res_valid) ? mem_res_data : '0;
    res_err       = w_fire && !mem_res_valid;
    mem_req_valid = r_state == S_ISSUE;
    mem_req_addr  = mem_req_valid ? r_addr : '0;
    mem_req_data  = mem_req_valid ? r_data : '0;
    mem_req_fcn   = mem_req_valid ? r_fcn : '0;
    mem_req_typ   = mem_req_valid ? r_typ : '0;
    grant         = r_state != S_IDLE ? {1'b0, w_own_oh} : '0;
    spurious      = r_spur;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_fcn   <= '0;
      r_typ   <= '0;
      r_spur  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_win;
        r_addr  <= w_addr_all[{w_win, 5'b0} +: 32];
        r_data  <= w_data_all[{w_win, 5'b0} +: 32];
        r_fcn   <= w_fcn_all[{w_win, 1'b0} +: 2];
        r_typ   <= w_typ_all[4'(w_win) * 4'd3 +: 3];
      end
      // Counter only runs in WAIT, so backpressure in ISSUE never ages the transaction.
      r_cnt <= (r_state == S_WAIT) ? r_cnt + 8'd1 : 8'd0;
      if (w_fire) r_rr <= (r_owner == 2'(NUM_REQ - 1)) ? 2'd0 : r_owner + 2'd1;
      if (mem_res_valid && r_state != S_WAIT) r_spur <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_mem_port_arbiter;
  localparam int N  = 2;
  localparam int TO = 4;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [31:0]    a_addr[N];
  logic [31:0]    a_data[N];
  logic [1:0]     a_fcn[N];
  logic [2:0]     a_typ[N];
  logic [N*32-1:0] req_addr, req_data;
  logic [N*2-1:0] req_fcn;
  logic [N*3-1:0] req_typ;
  logic [N-1:0]   req_ready, res_valid;
  logic [31:0]    res_data;
  logic           res_err;
  logic           mem_req_valid;
  logic [31:0]    mem_req_addr, mem_req_data;
  logic [1:0]     mem_req_fcn;
  logic [2:0]     mem_req_typ;
  logic           mem_req_ready, mem_res_valid;
  logic [31:0]    mem_res_data;
  logic [4:0]     grant;
  logic           spurious;
  assign req_addr = {a_addr[1], a_addr[0]};
  assign req_data = {a_data[1], a_data[0]};
  assign req_fcn  = {a_fcn[1], a_fcn[0]};
  assign req_typ  = {a_typ[1], a_typ[0]};
  mem_port_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_fcn(req_fcn), .req_typ(req_typ), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_fcn(mem_req_fcn),
    .mem_req_typ(mem_req_typ), .mem_req_ready(mem_req_ready),
    .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data),
    .grant(grant), .spurious(spurious)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  int order[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [31:0] ad, input logic [31:0] d,
                         input logic [1:0] f, input logic [2:0] t);
    a_addr[i] = ad;
    a_data[i] = d;
    a_fcn[i]  = f;
    a_typ[i]  = t;
  endtask
  // From an IDLE cycle with requests driven: accept, hold ISSUE for bp cycles,
  // wait lat WAIT cycles, then optionally respond.
  task automatic run_txn(input int bp, input int lat, input bit resp,
                         input logic [31:0] d, input bit drop);
    step;
    if (drop) req_valid = '0;
    mem_req_ready = 1'b0;
    repeat (bp) step;
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    repeat (lat) step;
    if (resp) begin
      mem_res_valid = 1'b1;
      mem_res_data  = d;
      step;
      mem_res_valid = 1'b0;
      mem_res_data  = '0;
    end
  endtask
  // Reference model: a transaction is either absent, accepted-but-not-issued, or issued and aging.
  bit          m_busy, m_issued, m_spur, m_fire;
  int          m_waits, m_owner, m_rr, m_win;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_fcn;
  logic [2:0]  m_typ;
  logic [N-1:0] e_ready, e_rv;
  logic [31:0] e_rd, e_addr, e_data;
  logic        e_err, e_mv, e_sp;
  logic [1:0]  e_fcn;
  logic [2:0]  e_typ;
  logic [4:0]  e_gr;
  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_issued = 0; m_spur = 0; m_waits = 0; m_owner = 0; m_rr = 0;
      e_ready = '0; e_rv = '0; e_rd = '0; e_err = 0; e_mv = 0;
      e_addr = '0; e_data = '0; e_fcn = '0; e_typ = '0; e_gr = '0; e_sp = 0;
      m_fire = 0; m_win = -1;
    end else begin
      m_win   = m_busy ? -1 : pick(req_valid, m_rr);
      e_ready = (m_win >= 0) ? N'(1 << m_win) : '0;
      e_mv    = m_busy && !m_issued;
      e_addr  = e_mv ? m_addr : '0;
      e_data  = e_mv ? m_data : '0;
      e_fcn   = e_mv ? m_fcn : '0;
      e_typ   = e_mv ? m_typ : '0;
      m_fire  = m_busy && m_issued && (mem_res_valid || m_waits + 1 == TO);
      e_rv    = m_fire ? N'(1 << m_owner) : '0;
      e_rd    = (m_fire && mem_res_valid) ? mem_res_data : '0;
      e_err   = m_fire && !mem_res_valid;
      e_gr    = m_busy ? 5'(1 << m_owner) : '0;
      e_sp    = m_spur;
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("res_valid", 32'(res_valid), 32'(e_rv));
    chk("res_data", res_data, e_rd);
    chk("res_err", 32'(res_err), 32'(e_err));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(e_mv));
    chk("mem_req_addr", mem_req_addr, e_addr);
    chk("mem_req_data", mem_req_data, e_data);
    chk("mem_req_fcn", 32'(mem_req_fcn), 32'(e_fcn));
    chk("mem_req_typ", 32'(mem_req_typ), 32'(e_typ));
    chk("grant", 32'(grant), 32'(e_gr));
    chk("spurious", 32'(spurious), 32'(e_sp));
    if (rst_n) begin
      if (mem_res_valid && !(m_busy && m_issued)) m_spur = 1;
      if (!m_busy) begin
        if (m_win >= 0) begin
          m_busy = 1; m_issued = 0; m_owner = m_win;
          m_addr = a_addr[m_win]; m_data = a_data[m_win];
          m_fcn = a_fcn[m_win]; m_typ = a_typ[m_win];
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin m_issued = 1; m_waits = 0; end
      end else if (m_fire) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % N;
      end else m_waits++;
    end
  end
  always @(negedge clk) if (rst_n && req_ready != '0) order.push_back(req_ready[1] ? 1 : 0);
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    req_valid = '0; mem_req_ready = 0; mem_res_valid = 0; mem_res_data = '0;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, '0, '0);
    step; step;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'h0);
    step;
    rst_n = 1'b1;
    // contention: both requesters held for four transactions
    set_req(0, 32'h1000, 32'hA0, 2'd1, 3'd4);
    set_req(1, 32'h2000, 32'hB1, 2'd3, 3'd2);
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) run_txn(0, 0, 1, 32'hC0DE0000 + 32'(t), 0);
    req_valid = '0;
    chk("rr_order_len", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(i % 2));
    // single read
    set_req(0, 32'h100, 32'h0, 2'd0, 3'd4);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rd_ready", 32'(req_ready), 32'h1);
    step;
    req_valid = '0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rd_mem_valid", 32'(mem_req_valid), 32'h1);
    chk("rd_mem_addr", mem_req_addr, 32'h100);
    step;
    mem_req_ready = 1'b0;
    step;
    mem_res_valid = 1'b1;
    mem_res_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_res_valid", 32'(res_valid), 32'h1);
    chk("rd_res_data", res_data, 32'hDEADBEEF);
    chk("rd_res_err", 32'(res_err), 32'h0);
    step;
    mem_res_valid = 1'b0;
    mem_res_data = '0;
    // backpressure longer than TIMEOUT, then a late-but-valid response; requester drops valid
    set_req(1, 32'h300, 32'h55AA, 2'd1, 3'd5);
    req_valid = 2'b10;
    run_txn(5, 2, 1, 32'hFEED0001, 1);
    // timeout on requester 0
    set_req(0, 32'h400, 32'h77, 2'd0, 3'd1);
    req_valid = 2'b01;
    step;
    req_valid = '0;
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    repeat (3) step;
    @(negedge clk);
    chk("to_res_valid", 32'(res_valid), 32'h1);
    chk("to_res_err", 32'(res_err), 32'h1);
    chk("to_res_data", res_data, 32'h0);
    step;
    @(negedge clk);
    chk("to_grant_idle", 32'(grant), 32'h0);
    // response coinciding with the timeout cycle on requester 1
    set_req(1, 32'h500, 32'h88, 2'd3, 3'd0);
    req_valid = 2'b10;
    step;
    req_valid = '0;
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    repeat (3) step;
    mem_res_valid = 1'b1;
    mem_res_data = 32'h12345678;
    @(negedge clk);
    chk("co_res_valid", 32'(res_valid), 32'h2);
    chk("co_res_err", 32'(res_err), 32'h0);
    chk("co_res_data", res_data, 32'h12345678);
    step;
    mem_res_valid = 1'b0;
    mem_res_data = '0;
    // spurious response in IDLE
    @(negedge clk);
    chk("sp_before", 32'(spurious), 32'h0);
    step;
    mem_res_valid = 1'b1;
    mem_res_data = 32'hBAD;
    @(negedge clk);
    chk("sp_res_valid", 32'(res_valid), 32'h0);
    step;
    mem_res_valid = 1'b0;
    mem_res_data = '0;
    @(negedge clk);
    chk("sp_flag", 32'(spurious), 32'h1);
    step;
    // move rr to 1 so the reset check shows it returns to 0
    set_req(0, 32'h600, 32'h99, 2'd0, 3'd2);
    req_valid = 2'b01;
    run_txn(0, 0, 1, 32'h600D, 1);
    // reset during WAIT
    req_valid = 2'b11;
    step;
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    mem_res_valid = 1'b1;
    #1;
    chk("rs_grant", 32'(grant), 32'h0);
    chk("rs_res_valid", 32'(res_valid), 32'h0);
    chk("rs_req_ready", 32'(req_ready), 32'h0);
    chk("rs_mem_valid", 32'(mem_req_valid), 32'h0);
    chk("rs_spurious", 32'(spurious), 32'h0);
    step;
    mem_res_valid = 1'b0;
    step;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_first_ready", 32'(req_ready), 32'h1);
    run_txn(0, 1, 1, 32'hCAFE, 1);
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
